osc_clk_sequencer: RTL

OSC_CLK_SEQUENCER -- requirements
Module: osc_clk_sequencer

---
 rtl/osc_clk_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/osc_clk_sequencer.sv
// Oscillator clock sequencer: HOLD -> STAB -> RUN with microsecond/millisecond ticks.
// Optional uptime counter built only when OSC_SEQ_UPTIME_EN is defined.
module osc_clk_sequencer #(
  parameter int STAB_CYCLES = 1024,
  parameter int US_DIV      = 160,
  parameter int MS_DIV      = 1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  output logic        READY,
  output logic        RESET_N_OUT,
  output logic        TICK_US,
  output logic        TICK_MS,
  output logic [31:0] UPTIME_MS
);

  localparam logic [15:0] STAB_LAST = 16'(STAB_CYCLES - 1);
  localparam logic [11:0] US_LAST   = 12'(US_DIV - 1);
  localparam logic [11:0] US_PRE    = 12'(US_DIV - 2);
  localparam logic [11:0] MS_LAST   = 12'(MS_DIV - 1);

  typedef enum logic [1:0] {HOLD, STAB, RUN} state_e;

  state_e      state_q;
  logic [15:0] stab_q;
  logic [11:0] us_q;
  logic [11:0] ms_q;
  logic        ready_q;
  logic        rstn_q;
  logic        tick_us_q;
  logic        tick_ms_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= HOLD;
      stab_q    <= '0;
      us_q      <= '0;
      ms_q      <= '0;
      ready_q   <= 1'b0;
      rstn_q    <= 1'b0;
      tick_us_q <= 1'b0;
      tick_ms_q <= 1'b0;
    end else begin
      tick_us_q <= 1'b0;
      tick_ms_q <= 1'b0;
      if (!ENABLE) begin
        // Dropping ENABLE beats every other transition, including STAB->RUN
        state_q <= HOLD;
        stab_q  <= '0;
        us_q    <= '0;
        ms_q    <= '0;
        ready_q <= 1'b0;
        rstn_q  <= 1'b0;
      end else begin
        case (state_q)
          HOLD: begin
            state_q <= STAB;
            stab_q  <= '0;
          end
          STAB: begin
            if (stab_q == STAB_LAST) begin
              state_q <= RUN;
              stab_q  <= '0;
              us_q    <= '0;
              ms_q    <= '0;
              ready_q <= 1'b1;
              rstn_q  <= 1'b1;
            end else begin
              stab_q <= stab_q + 16'd1;
            end
          end
          RUN: begin
            // Ticks are registered, so decode one count early to land on US_DIV-1
            tick_us_q <= (us_q == US_PRE);
            tick_ms_q <= (us_q == US_PRE) && (ms_q == MS_LAST);
            if (us_q == US_LAST) begin
              us_q <= '0;
              ms_q <= (ms_q == MS_LAST) ? 12'd0 : ms_q + 12'd1;
            end else begin
              us_q <= us_q + 12'd1;
            end
          end
          default: state_q <= HOLD;
        endcase
      end
    end
  end

`ifdef OSC_SEQ_UPTIME_EN
  logic [31:0] uptime_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      uptime_q <= '0;
    end else if (tick_ms_q) begin
      uptime_q <= uptime_q + 32'd1;
    end
  end

  assign UPTIME_MS = uptime_q;
`else
  assign UPTIME_MS = 32'h0;
`endif

  assign READY       = ready_q;
  assign RESET_N_OUT = rstn_q;
  assign TICK_US     = tick_us_q;
  assign TICK_MS     = tick_ms_q;

endmodule
